// File: rtl/v2_peak_detector.sv
// Pulse peak detector behind the v2 trapezoidal shaper: tracks each over-threshold
// pulse, reports amplitude/time/width over valid/ready, then applies a dead time.
module v2_peak_detector #(
    parameter int DATA_W    = 16,
    parameter int TS_W      = 32,
    parameter int WIDTH_W   = 8,
    parameter int MIN_WIDTH = 2,
    parameter int HOLDOFF   = 16,
    parameter int DROP_W    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] filter_data,
    input  logic signed [DATA_W-1:0] threshold,
    input  logic                     peak_ready,
    output logic                     peak_valid,
    output logic signed [DATA_W-1:0] peak_amp,
    output logic [TS_W-1:0]          peak_time,
    output logic [WIDTH_W-1:0]       peak_width,
    output logic [DROP_W-1:0]        drop_cnt,
    output logic                     busy
);

    localparam int HOLD_W = $clog2(HOLDOFF + 2);
    localparam logic [WIDTH_W-1:0] MIN_WIDTH_L = WIDTH_W'(MIN_WIDTH);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD   = HOLD_W'(HOLDOFF - 1);

    typedef enum logic [1:0] {IDLE, TRACK, REPORT, HOLD} state_t;

    state_t                    state_reg, state_next;
    logic signed [DATA_W-1:0]  sample_reg;
    logic                      above_q_reg;
    logic [TS_W-1:0]           ts_reg;
    logic signed [DATA_W-1:0]  max_reg, max_next;
    logic [TS_W-1:0]           max_time_reg, max_time_next;
    logic [WIDTH_W-1:0]        width_reg, width_next;
    logic                      valid_reg, valid_next;
    logic signed [DATA_W-1:0]  amp_reg, amp_next;
    logic [TS_W-1:0]           time_reg, time_next;
    logic [WIDTH_W-1:0]        pwidth_reg, pwidth_next;
    logic [HOLD_W-1:0]         hold_reg, hold_next;
    logic [DROP_W-1:0]         drop_reg, drop_next;

    logic above;
    logic rise;

    assign above = (sample_reg >= threshold);
    assign rise  = above & ~above_q_reg;

    // above_q resets high so a level already above threshold cannot trigger
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            sample_reg   <= '0;
            above_q_reg  <= 1'b1;
            ts_reg       <= '0;
            max_reg      <= '0;
            max_time_reg <= '0;
            width_reg    <= '0;
            valid_reg    <= 1'b0;
            amp_reg      <= '0;
            time_reg     <= '0;
            pwidth_reg   <= '0;
            hold_reg     <= '0;
            drop_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            sample_reg   <= filter_data;
            above_q_reg  <= above;
            ts_reg       <= ts_reg + TS_W'(1);
            max_reg      <= max_next;
            max_time_reg <= max_time_next;
            width_reg    <= width_next;
            valid_reg    <= valid_next;
            amp_reg      <= amp_next;
            time_reg     <= time_next;
            pwidth_reg   <= pwidth_next;
            hold_reg     <= hold_next;
            drop_reg     <= drop_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        max_next      = max_reg;
        max_time_next = max_time_reg;
        width_next    = width_reg;
        valid_next    = valid_reg;
        amp_next      = amp_reg;
        time_next     = time_reg;
        pwidth_next   = pwidth_reg;
        hold_next     = hold_reg;
        drop_next     = drop_reg;

        case (state_reg)
            IDLE: begin
                if (rise) begin
                    state_next    = TRACK;
                    max_next      = sample_reg;
                    max_time_next = ts_reg;
                    width_next    = WIDTH_W'(1);
                end
            end
            TRACK: begin
                if (above) begin
                    if (width_reg != '1) begin
                        width_next = width_reg + WIDTH_W'(1);
                    end
                    // strict compare keeps the earliest sample of a tied maximum
                    if (sample_reg > max_reg) begin
                        max_next      = sample_reg;
                        max_time_next = ts_reg;
                    end
                end else if (width_reg < MIN_WIDTH_L) begin
                    state_next = IDLE;
                end else begin
                    state_next  = REPORT;
                    valid_next  = 1'b1;
                    amp_next    = max_reg;
                    time_next   = max_time_reg;
                    pwidth_next = width_reg;
                end
            end
            REPORT: begin
                if (valid_reg && peak_ready) begin
                    valid_next = 1'b0;
                    if (HOLDOFF == 0) begin
                        state_next = IDLE;
                    end else begin
                        state_next = HOLD;
                        hold_next  = HOLD_LOAD;
                    end
                end
            end
            HOLD: begin
                if (hold_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    hold_next = hold_reg - HOLD_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        if ((state_reg == REPORT || state_reg == HOLD) && rise && drop_reg != '1) begin
            drop_next = drop_reg + DROP_W'(1);
        end
    end

    assign peak_valid = valid_reg;
    assign peak_amp   = amp_reg;
    assign peak_time  = time_reg;
    assign peak_width = pwidth_reg;
    assign drop_cnt   = drop_reg;
    assign busy       = (state_reg != IDLE);

endmodule
